// File: rtl/spi_pkg.sv
// Shared SPI types and constants: FSM state encoding, data width and the mode-0 clock setup.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    CS_END
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Loadable down-counter: after a load, o_tick rises CLK_DIV cycles later (CLK_DIV-1 counts + 1).
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Counter parks at zero; the FSM reloads it on every state change, so tick lasts one cycle there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master with valid/ready byte input, burst chip-select hold and rx strobe.
// Handshake: a byte is taken on any clk edge where tx_valid && tx_ready; tx_ready is high only in IDLE/HOLD.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              hold_cs,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_cs,
  input  logic              spi_miso,
  output spi_state_e        dbg_state
);

  localparam logic SCK_IDLE = SPI_MODE0.cpol;

  spi_state_e        r_state;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_rx_data;
  logic [2:0]        r_bit_cnt;
  logic              r_hold;
  logic              r_cs;
  logic              r_sck;
  logic              r_mosi;
  logic              r_ready;
  logic              r_rx_valid;
  logic              r_busy;

  logic              w_tick;
  logic              w_load;

  // Reload the divider on exactly the cycles where the FSM below changes state.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      IDLE:    w_load = tx_valid;
      HOLD:    w_load = tx_valid | ~hold_cs;
      default: w_load = w_tick;
    endcase
  end

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_hold     <= 1'b0;
      r_cs       <= 1'b1;
      r_sck      <= SCK_IDLE;
      r_mosi     <= 1'b0;
      r_ready    <= 1'b1;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if (tx_valid) begin
            r_state   <= SETUP;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_mosi    <= tx_data[DATA_W-1];
            r_tx_sr   <= {tx_data[DATA_W-2:0], 1'b0};
            r_hold    <= hold_cs;
            r_bit_cnt <= '0;
          end else if (r_state == HOLD && !hold_cs) begin
            r_state <= CS_END;
            r_ready <= 1'b0;
          end
        end
        SETUP, SCK_LO: begin
          if (w_tick) begin
            r_state <= SCK_HI;
            r_sck   <= ~SCK_IDLE;
            r_rx_sr <= {r_rx_sr[DATA_W-2:0], spi_miso};
          end
        end
        SCK_HI: begin
          if (w_tick) begin
            r_sck <= SCK_IDLE;
            // Last bit: no SCK_LO phase; the falling edge itself completes the byte.
            if (r_bit_cnt == 3'd7) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx_sr;
              if (r_hold) begin
                r_state <= HOLD;
                r_ready <= 1'b1;
              end else begin
                r_state <= CS_END;
              end
            end else begin
              r_state   <= SCK_LO;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_mosi    <= r_tx_sr[DATA_W-1];
              r_tx_sr   <= {r_tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        CS_END: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_mosi  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_sck   <= SCK_IDLE;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = r_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = r_busy;
  assign spi_sck   = r_sck;
  assign spi_mosi  = r_mosi;
  assign spi_cs    = r_cs;
  assign dbg_state = r_state;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master (mode 0: CPOL=0, CPHA=0, MSB first) driving `spi_sck`/`spi_mosi`/`spi_cs` and sampling `spi_miso`.
- Counterpart of the existing `spi_slave` top-level, which it drives on the same four-wire bus.
- Used as the host-side link for on-chip loopback and board-to-board tests of the pricing accelerator.
- Provides a valid/ready byte interface toward core logic and a one-cycle `rx_valid` strobe per completed byte.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (≥1); SCK frequency = f_clk / (2*CLK_DIV)
- DATA_W, 8, bits per transfer (fixed 8 for this revision; parameter kept for package consistency)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  master can accept a byte this cycle
- hold_cs  in  1  sampled at accept; 1 = keep CS low after this byte (burst)
- rx_data  out  8  last received byte, stable until next rx_valid
- rx_valid  out  1  one-cycle strobe, rx_data updated
- busy  out  1  high whenever spi_cs is low
- spi_sck  out  1  SPI clock, idles low
- spi_mosi  out  1  master out, changes on SCK falling edge
- spi_cs  out  1  chip select, active low
- spi_miso  in  1  slave out, sampled on SCK rising edge

Behaviour:
- Reset (async assert, sync release): spi_cs=1, spi_sck=0, spi_mosi=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, state=IDLE. Reset mid-transfer aborts immediately; no rx_valid.
- All outputs are registered.
- States:
  - IDLE: cs high, ready=1.
  - SETUP: cs low, mosi=bit7, count CLK_DIV cycles.
  - SCK_HI: sck=1 for CLK_DIV cycles; miso sampled on the cycle sck goes high.
  - SCK_LO: sck=0 for CLK_DIV cycles; shift next bit to mosi on entry.
  - HOLD: cs low, sck low, ready=1.
  - CS_END: cs low, CLK_DIV cycles of hold time, then cs high.
- Accept = tx_valid & tx_ready at a clk edge (cycle 0). The byte and hold_cs are latched.
- Cycle 1: cs=0, mosi=tx_data[7], state SETUP.
- SCK rising edges occur at cycles 1+CLK_DIV+2k*CLK_DIV, k=0..7.
- The falling edge after rising edge k drives mosi=tx_data[6-k] for k<7.
- After the 8th rising edge: sck falls after CLK_DIV cycles. In that same cycle, rx_valid=1 and rx_data=shifted byte (cycle 1+16*CLK_DIV; 33 for CLK_DIV=2).
- Then:
  - If latched hold_cs=0: CS_END, with spi_cs=1 and tx_ready=1 CLK_DIV cycles later.
  - Otherwise: HOLD.
- HOLD:
  - tx_valid=1: accept and go to SETUP timing as above, with cs staying low. tx_valid takes priority over a simultaneous hold_cs=0.
  - tx_valid=0 and hold_cs=0: CS_END.
- tx_ready=0 in SETUP, SCK_HI, SCK_LO and CS_END. tx_valid there is ignored, and tx_data changes there have no effect.
- mosi holds its last bit in HOLD and CS_END; it is driven 0 in IDLE.
- busy = ~spi_cs.
- Bit counter is 3 bits and wraps only through state transition, never free-running. Divider counter is $clog2(CLK_DIV+1) bits and reloads on every state entry.
- rx shift: rx_sr <= {rx_sr[6:0], spi_miso} on each SCK rising cycle.

Decomposition:
- Shared package `spi_pkg`:
  - state enum (IDLE, SETUP, SCK_HI, SCK_LO, HOLD, CS_END)
  - SPI_DATA_W=8
  - SPI_MODE0 constants (CPOL=0, CPHA=0)
- Sub-module `spi_tick_gen`: loadable down-counter producing a one-cycle tick after CLK_DIV cycles; reloaded by the FSM on each state change.
- FSM and shift registers stay in `spi_master`.

Test Plan:
- Reset: hold rst_n=0, then toggle clk -> spi_cs=1, spi_sck=0, spi_mosi=0, tx_ready=1, rx_valid=0, rx_data=0x00. Assert rst_n=0 asynchronously mid-cycle during a transfer -> outputs return to these values before the next clk edge.
- Single byte, CLK_DIV=2: tx_data=0xA5, hold_cs=0, slave model returns 0x3C. Required response:
  - mosi bits 1,0,1,0,0,1,0,1, checked at each sck rise
  - exactly 8 sck pulses, each 2 clk high and 2 low
  - rx_valid pulse at cycle 33 with rx_data=0x3C
  - spi_cs=1 at cycle 35
- Burst: 0x12 with hold_cs=1, then 0x34 presented 3 cycles after the first rx_valid with hold_cs=0 -> spi_cs low continuously across both bytes, 16 sck pulses total, two rx_valid strobes, cs rises CLK_DIV cycles after the second.
- Busy ignore: assert tx_valid with 0xFF while a 0x0F transfer is in SCK_HI -> tx_ready=0, mosi stream is still 0x0F, and only one rx_valid occurs.
- HOLD exit: after one byte with hold_cs=1, drop hold_cs with tx_valid=0 -> CS_END, then spi_cs=1 after CLK_DIV cycles. Drop hold_cs in the same cycle as tx_valid=1 -> a new byte starts and cs stays low.
- Loopback with the existing `spi_slave` (CLK_DIV=1 and 4), sending 0x00, 0xFF, 0x5A -> slave data/data_ready matches each byte and no extra sck edges occur.
